neuro_core_arbiter: RTL
=======================

Name: neuro_core_arbiter

Overview:
- Shares the single ReRAM functional core between two requesters.
  - Port A: Wishbone host path.
  - Port B: local on-chip sequencer, e.g. an array init/refresh engine.
- Round-robin arbitration; one outstanding operation at a time.
- Drives the core command pins (EN, R_WB, AD, DI, SEL) and waits for func_ack, with a timeout.
- Returns read data and a per-requester ack/err pulse.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles in BUSY without func_ack before the operation is aborted.
- ERR_DATA, 32'hDEAD_BEEF: value returned on x_dat_o when a timeout occurs.
- CNT_W, 8: width of the saturating timeout-event counter.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  synchronous, active-high reset.
- a_req_i  in  1  requester A command valid (level).
- a_we_i  in  1  A direction: 1 = read, 0 = write (same sense as R_WB).
- a_adr_i  in  32  A address.
- a_dat_i  in  32  A write data.
- a_sel_i  in  4  A byte select.
- a_ack_o  out  1  A completion pulse, one cycle.
- a_err_o  out  1  A timeout flag, valid with a_ack_o.
- a_dat_o  out  32  A read data, valid with a_ack_o.
- b_req_i, b_we_i, b_adr_i, b_dat_i, b_sel_i, b_ack_o, b_err_o, b_dat_o: same as the A ports, for requester B.
- R_WB  out  1  to core: 1 = read, 0 = write.
- EN  out  1  to core: operation enable.
- AD  out  32  to core: address.
- DI  out  32  to core: write data.
- SEL  out  4  to core: byte select.
- DO  in  32  from core: read data.
- func_ack  in  1  from core: operation complete.
- owner_o  out  1  current/last grant: 0 = A, 1 = B.
- busy_o  out  1  high in BUSY and RESP.
- tmo_cnt_o  out  CNT_W  saturating count of timeouts.

Behaviour:
- Reset (sampled at the wb_clk_i edge):
  - All outputs go to 0; owner_o = 1, so A wins the first tie; state = IDLE; timer = 0; tmo_cnt_o = 0.
  - Reset during BUSY or RESP drops the in-flight operation: no ack, no err.
- All outputs are registered.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE, EN = 0.
  - Only one request high: grant it.
  - Both high: grant the port that is not owner_o (round-robin).
  - On grant, latch that port's we/adr/dat/sel into R_WB/AD/DI/SEL, set EN = 1, set owner_o, clear the timer, go to BUSY.
  - Latency: request seen at edge k; EN is high after edge k.
- BUSY:
  - EN, R_WB, AD, DI, SEL are held constant.
  - Timer increments each cycle.
  - If func_ack = 1:
    - Capture DO into the granted port's x_dat_o.
    - Pulse x_ack_o = 1, x_err_o = 0.
    - Clear EN; go to RESP.
  - Else if timer == TIMEOUT_CYCLES-1:
    - Set x_dat_o = ERR_DATA, x_ack_o = 1, x_err_o = 1.
    - Clear EN; increment tmo_cnt_o, saturating at all-ones; go to RESP.
  - func_ack and timeout expiry in the same cycle: func_ack wins, no error.
- RESP:
  - x_ack_o / x_err_o drop to 0; x_dat_o holds its value until the next completion for that port.
  - EN = 0.
  - Always go to IDLE next.
  - Guarantees at least 2 idle cycles with EN = 0 between core operations.
- Requester rules:
  - Command fields must be stable while x_req_i is high and x_ack_o has not yet been seen.
  - A requester may keep req high after ack to issue the next command; it re-enters arbitration in IDLE.
  - Dropping req during BUSY does not abort; the op completes and the ack is still pulsed.
- func_ack in IDLE or RESP is spurious: ignored, no state change.
- Write ops (R_WB = 0) still capture DO on ack; value is don't-care to the requester.
- Only one of a_ack_o / b_ack_o is ever high in a cycle.

Decomposition:
- Shared package neuro_core_pkg:
  - state encoding constants (IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2);
  - R_WB_READ = 1'b1, R_WB_WRITE = 1'b0.
- One sub-module: neuro_rr_arb2 (combinational 2-way round-robin pick from req_a, req_b, last_owner).
- Timer and FSM stay in the top.

Test Plan:
- Reset, then A read (adr 32'h3000_000c, sel 4'hF); core acks 3 cycles after EN with DO = 32'h1234_5678.
  - EN high for 3 cycles; a_ack_o one-cycle pulse; a_dat_o = 32'h1234_5678; a_err_o = 0; EN low for 2 cycles after.
- A and B requesting continuously from reset, each op acked after 1 cycle.
  - Grants alternate A, B, A, B; owner_o toggles; never both acks in one cycle.
- B write (dat 32'hA5A5_0F0F) with func_ack never asserted, TIMEOUT_CYCLES = 16.
  - EN drops after 16 BUSY cycles; b_ack_o = 1, b_err_o = 1, b_dat_o = 32'hDEAD_BEEF; tmo_cnt_o = 1.
- func_ack asserted on the exact timeout cycle.
  - Normal completion: err = 0, DO returned, tmo_cnt_o unchanged.
- wb_rst_i pulsed for 1 cycle mid-BUSY.
  - Next cycle: EN = 0, state IDLE, no ack on either port; later func_ack is ignored.
- Spurious func_ack in IDLE, then A request.
  - No ack output from the spurious pulse; A completes normally on its own func_ack.

Source files
------------

// File: rtl/neuro_core_pkg.sv
// Shared definitions for the ReRAM core arbiter.
// Holds the FSM state encoding, the R_WB direction encoding and the owner
// encoding used by neuro_core_arbiter and neuro_rr_arb2.
package neuro_core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic R_WB_READ  = 1'b1;
    localparam logic R_WB_WRITE = 1'b0;

    // owner_o encoding: which requester holds / last held the core
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/neuro_rr_arb2.sv
// Combinational two-way round-robin pick.
// Ports:
//   req_a, req_b  in   request levels of requester A and B
//   last_owner    in   previous grant (0 = A, 1 = B); loses a tie
//   grant_valid   out  at least one request is present
//   grant_b       out  1 = pick B, 0 = pick A (meaningful with grant_valid)
module neuro_rr_arb2
    import neuro_core_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_b
);

    // Pick a requester; on a tie the one that did not go last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_b     = OWNER_A;
        case ({req_a, req_b})
            2'b10: begin
                grant_valid = 1'b1;
                grant_b     = OWNER_A;
            end
            2'b01: begin
                grant_valid = 1'b1;
                grant_b     = OWNER_B;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_b     = ~last_owner;
            end
            default: begin
                grant_valid = 1'b0;
                grant_b     = OWNER_A;
            end
        endcase
    end

endmodule

// File: rtl/neuro_core_arbiter.sv
// Shares one ReRAM functional core between requester A (Wishbone host path)
// and requester B (local sequencer). Round-robin grant, one operation in
// flight, per-operation timeout, per-requester ack/err/data return.
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   a_*/b_* req/we/adr/dat/sel   requester command inputs (we: 1 = read)
//   a_*/b_* ack/err/dat (out)    one-cycle completion, timeout flag, read data
//   R_WB, EN, AD, DI, SEL        core command pins (registered)
//   DO, func_ack                 core read data and completion
//   owner_o                      current/last grant (0 = A, 1 = B)
//   busy_o                       high while in BUSY or RESP
//   tmo_cnt_o                    saturating count of timed-out operations
module neuro_core_arbiter
    import neuro_core_pkg::*;
#(
    parameter int unsigned    TIMEOUT_CYCLES = 1024,
    parameter logic [31:0]    ERR_DATA       = 32'hDEAD_BEEF,
    parameter int unsigned    CNT_W          = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             a_req_i,
    input  logic             a_we_i,
    input  logic [31:0]      a_adr_i,
    input  logic [31:0]      a_dat_i,
    input  logic [3:0]       a_sel_i,
    output logic             a_ack_o,
    output logic             a_err_o,
    output logic [31:0]      a_dat_o,
    input  logic             b_req_i,
    input  logic             b_we_i,
    input  logic [31:0]      b_adr_i,
    input  logic [31:0]      b_dat_i,
    input  logic [3:0]       b_sel_i,
    output logic             b_ack_o,
    output logic             b_err_o,
    output logic [31:0]      b_dat_o,
    output logic             R_WB,
    output logic             EN,
    output logic [31:0]      AD,
    output logic [31:0]      DI,
    output logic [3:0]       SEL,
    input  logic [31:0]      DO,
    input  logic             func_ack,
    output logic             owner_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] tmo_cnt_o
);

    // Timer only needs to reach TIMEOUT_CYCLES-1; one spare bit keeps the
    // increment from wrapping for any parameter value.
    localparam int unsigned       TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMR_W-1:0]  TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t             state_r, state_s;
    logic               en_r, en_s;
    logic               rwb_r, rwb_s;
    logic [31:0]        ad_r, ad_s;
    logic [31:0]        di_r, di_s;
    logic [3:0]         sel_r, sel_s;
    logic               owner_r, owner_s;
    logic               busy_r, busy_s;
    logic [TMR_W-1:0]   timer_r, timer_s;
    logic [CNT_W-1:0]   tmo_r, tmo_s;
    logic               a_ack_r, a_ack_s, a_err_r, a_err_s;
    logic               b_ack_r, b_ack_s, b_err_r, b_err_s;
    logic [31:0]        a_dat_r, a_dat_s, b_dat_r, b_dat_s;
    logic               grant_valid_s;
    logic               grant_b_s;

    neuro_rr_arb2 u_arb (
        .req_a       (a_req_i),
        .req_b       (b_req_i),
        .last_owner  (owner_r),
        .grant_valid (grant_valid_s),
        .grant_b     (grant_b_s)
    );

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s = state_r;
        en_s    = en_r;
        rwb_s   = rwb_r;
        ad_s    = ad_r;
        di_s    = di_r;
        sel_s   = sel_r;
        owner_s = owner_r;
        timer_s = timer_r;
        tmo_s   = tmo_r;
        a_ack_s = 1'b0;
        a_err_s = 1'b0;
        a_dat_s = a_dat_r;
        b_ack_s = 1'b0;
        b_err_s = 1'b0;
        b_dat_s = b_dat_r;

        case (state_r)
            IDLE: begin
                en_s = 1'b0;
                if (grant_valid_s) begin
                    owner_s = grant_b_s;
                    en_s    = 1'b1;
                    timer_s = '0;
                    state_s = BUSY;
                    if (grant_b_s == OWNER_B) begin
                        rwb_s = b_we_i;
                        ad_s  = b_adr_i;
                        di_s  = b_dat_i;
                        sel_s = b_sel_i;
                    end else begin
                        rwb_s = a_we_i;
                        ad_s  = a_adr_i;
                        di_s  = a_dat_i;
                        sel_s = a_sel_i;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                timer_s = timer_r + TMR_W'(1);
                // func_ack is tested first so it wins over a same-cycle expiry
                if (func_ack) begin
                    en_s    = 1'b0;
                    state_s = RESP;
                    if (owner_r == OWNER_B) begin
                        b_ack_s = 1'b1;
                        b_dat_s = DO;
                    end else begin
                        a_ack_s = 1'b1;
                        a_dat_s = DO;
                    end
                end else if (timer_r == TMO_LAST) begin
                    en_s    = 1'b0;
                    state_s = RESP;
                    if (tmo_r != CNT_MAX) begin
                        tmo_s = tmo_r + CNT_W'(1);
                    end else begin
                        tmo_s = tmo_r;
                    end
                    if (owner_r == OWNER_B) begin
                        b_ack_s = 1'b1;
                        b_err_s = 1'b1;
                        b_dat_s = ERR_DATA;
                    end else begin
                        a_ack_s = 1'b1;
                        a_err_s = 1'b1;
                        a_dat_s = ERR_DATA;
                    end
                end else begin
                    state_s = BUSY;
                end
            end
            RESP: begin
                // Together with the IDLE cycle this gives two EN-low cycles
                // between consecutive core operations.
                en_s    = 1'b0;
                state_s = IDLE;
            end
            default: begin
                en_s    = 1'b0;
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
            en_r    <= 1'b0;
            rwb_r   <= R_WB_WRITE;
            ad_r    <= 32'h0000_0000;
            di_r    <= 32'h0000_0000;
            sel_r   <= 4'h0;
            owner_r <= OWNER_B;
            busy_r  <= 1'b0;
            timer_r <= '0;
            tmo_r   <= '0;
            a_ack_r <= 1'b0;
            a_err_r <= 1'b0;
            a_dat_r <= 32'h0000_0000;
            b_ack_r <= 1'b0;
            b_err_r <= 1'b0;
            b_dat_r <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            en_r    <= en_s;
            rwb_r   <= rwb_s;
            ad_r    <= ad_s;
            di_r    <= di_s;
            sel_r   <= sel_s;
            owner_r <= owner_s;
            busy_r  <= busy_s;
            timer_r <= timer_s;
            tmo_r   <= tmo_s;
            a_ack_r <= a_ack_s;
            a_err_r <= a_err_s;
            a_dat_r <= a_dat_s;
            b_ack_r <= b_ack_s;
            b_err_r <= b_err_s;
            b_dat_r <= b_dat_s;
        end
    end

    assign EN        = en_r;
    assign R_WB      = rwb_r;
    assign AD        = ad_r;
    assign DI        = di_r;
    assign SEL       = sel_r;
    assign owner_o   = owner_r;
    assign busy_o    = busy_r;
    assign tmo_cnt_o = tmo_r;
    assign a_ack_o   = a_ack_r;
    assign a_err_o   = a_err_r;
    assign a_dat_o   = a_dat_r;
    assign b_ack_o   = b_ack_r;
    assign b_err_o   = b_err_r;
    assign b_dat_o   = b_dat_r;

endmodule
